// File: rtl/boot_ram_loader.sv
// Copies a 16-bit boot ROM image into 32-bit program RAM, packing halfword pairs
// {even, odd} into words and writing them through a ready/valid port.
module boot_ram_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  rom_adr,
  input  logic [15:0] rom_dat,
  input  logic [15:0] romsiz,
  output logic [6:0]  ram_adr,
  output logic [31:0] ram_wdat,
  output logic        ram_we,
  input  logic        ram_rdy,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned ADR_W  = 8;
  localparam int unsigned DAT_W  = 16;
  localparam int unsigned HWC_W  = 9;
  localparam int unsigned WADR_W = 7;
  localparam int unsigned MAX_HW = 256;
  localparam int unsigned MAX_SZ = 512;

  typedef enum logic [2:0] {IDLE, RDH, RDL, WR, FIN} state_t;

  state_t              state, state_d;
  logic [ADR_W-1:0]    rom_adr_d;
  logic [WADR_W-1:0]   ram_adr_d;
  logic [31:0]         ram_wdat_d;
  logic                ram_we_d, busy_d, done_d, err_d;
  logic [HWC_W-1:0]    hwc, hwc_d, hwc_new;
  logic [ADR_W-1:0]    k, k_d, kn;
  logic [ADR_W-1:0]    k_odd;
  logic [HWC_W-1:0]    two_kn;
  logic [DAT_W-1:0]    hi, hi_d, lo;
  logic                err_new;

  // Halfword count is clamped to the 256-entry ROM; an oversize image flags err.
  assign hwc_new = (romsiz[15:1] > 15'(MAX_HW)) ? HWC_W'(MAX_HW) : romsiz[9:1];
  assign err_new = romsiz > 16'(MAX_SZ);
  assign kn      = k + 8'd1;
  assign two_kn  = {kn, 1'b0};
  assign k_odd   = {k[6:0], 1'b1};
  assign lo      = ({1'b0, k_odd} < hwc) ? rom_dat : 16'h0000;

  always_comb begin
    state_d    = state;
    rom_adr_d  = rom_adr;
    ram_adr_d  = ram_adr;
    ram_wdat_d = ram_wdat;
    ram_we_d   = ram_we;
    busy_d     = busy;
    done_d     = 1'b0;
    err_d      = err;
    hwc_d      = hwc;
    k_d        = k;
    hi_d       = hi;
    case (state)
      IDLE: begin
        busy_d   = 1'b0;
        ram_we_d = 1'b0;
        if (start) begin
          hwc_d     = hwc_new;
          k_d       = '0;
          err_d     = err_new;
          rom_adr_d = '0;
          busy_d    = 1'b1;
          if (hwc_new == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = RDH;
          end
        end
      end
      RDH: begin
        hi_d      = rom_dat;
        rom_adr_d = k_odd;
        state_d   = RDL;
      end
      RDL: begin
        ram_we_d   = 1'b1;
        ram_adr_d  = k[6:0];
        ram_wdat_d = {hi, lo};
        state_d    = WR;
      end
      WR: begin
        if (ram_rdy) begin
          ram_we_d = 1'b0;
          k_d      = kn;
          if (two_kn >= hwc) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            rom_adr_d = two_kn[7:0];
            state_d   = RDH;
          end
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All state and outputs registered; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rom_adr  <= '0;
      ram_adr  <= '0;
      ram_wdat <= '0;
      ram_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      hwc      <= '0;
      k        <= '0;
      hi       <= '0;
    end else begin
      state    <= state_d;
      rom_adr  <= rom_adr_d;
      ram_adr  <= ram_adr_d;
      ram_wdat <= ram_wdat_d;
      ram_we   <= ram_we_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      hwc      <= hwc_d;
      k        <= k_d;
      hi       <= hi_d;
    end
  end

endmodule

// File: tb/tb_boot_ram_loader.sv
// Scoreboard bench for boot_ram_loader: expected RAM writes are queued per copy
// and popped as the DUT's writes are accepted.
module tb_boot_ram_loader;

  logic        clk = 1'b0;
  logic        rst, start, ram_rdy, ram_we, busy, done, err;
  logic [7:0]  rom_adr;
  logic [15:0] rom_dat, romsiz;
  logic [6:0]  ram_adr;
  logic [31:0] ram_wdat;

  int total = 0;
  int bad   = 0;
  logic [38:0] sb[$];

  boot_ram_loader dut (
    .clk(clk), .rst(rst), .start(start), .rom_adr(rom_adr), .rom_dat(rom_dat),
    .romsiz(romsiz), .ram_adr(ram_adr), .ram_wdat(ram_wdat), .ram_we(ram_we),
    .ram_rdy(ram_rdy), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_val(input int i);
    return 16'h1000 + 16'(i);
  endfunction

  assign rom_dat = rom_val(int'(rom_adr));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write monitor: an accepted write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && ram_we) begin
      if (!busy) chk("we_while_idle", 32'(busy), 32'd1);
      if (ram_rdy) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'(ram_adr), 32'hffffffff);
        end else begin
          logic [38:0] e;
          e = sb.pop_front();
          chk("ram_adr", 32'(ram_adr), 32'(e[38:32]));
          chk("ram_wdat", ram_wdat, e[31:0]);
        end
      end
    end
  end

  task automatic do_copy(input logic [15:0] siz, input int stall, input bit extra_start);
    int hwc, nw, lat, wr_cnt, stall_seen, budget, n;
    bit got;
    logic exp_err;
    logic [31:0] first_dat;
    hwc     = (int'(siz) > 512) ? 256 : int'(siz[15:1]);
    exp_err = (int'(siz) > 512);
    nw      = (hwc + 1) / 2;
    for (int k = 0; k < nw; k++) begin
      logic [15:0] lo;
      lo = (2*k + 1 < hwc) ? rom_val(2*k + 1) : 16'h0000;
      sb.push_back({7'(k), rom_val(2*k), lo});
    end
    first_dat  = {rom_val(0), (hwc > 1) ? rom_val(1) : 16'h0000};
    budget     = 3*nw + stall + 30;
    wr_cnt     = 0;
    stall_seen = 0;
    got        = 1'b0;
    lat        = 0;
    @(posedge clk); #1;
    start   = 1'b1;
    romsiz  = siz;
    ram_rdy = (stall == 0);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (n == 0) chk("busy_after_start", 32'(busy), 32'd1);
      if (ram_we && ram_rdy) wr_cnt++;
      if (ram_we && !ram_rdy) begin
        stall_seen++;
        chk("stall_adr", 32'(ram_adr), 32'd0);
        chk("stall_dat", ram_wdat, first_dat);
      end
      if (done) begin
        lat = n + 1;
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      start  = extra_start && (n == 1);
      romsiz = start ? 16'hffff : siz;
      if (stall_seen >= stall) ram_rdy = 1'b1;
      n++;
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    chk("latency", 32'(lat), 32'(3*nw + 1 + stall));
    chk("write_count", 32'(wr_cnt), 32'(nw));
    chk("stall_cycles", 32'(stall_seen), 32'(stall));
    chk("err", 32'(err), 32'(exp_err));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    start   = 1'b0;
    ram_rdy = 1'b1;
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; romsiz = 16'h0; ram_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rom_adr", 32'(rom_adr), 32'd0);
    chk("rst_ram_adr", 32'(ram_adr), 32'd0);
    chk("rst_ram_wdat", ram_wdat, 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    do_copy(16'd8, 0, 1'b0);
    do_copy(16'd6, 0, 1'b0);
    do_copy(16'd4, 5, 1'b0);
    do_copy(16'h0400, 0, 1'b0);
    do_copy(16'd2, 0, 1'b0);
    do_copy(16'd0, 0, 1'b0);
    do_copy(16'd20, 0, 1'b1);
    do_copy(16'd9, 0, 1'b0);

    // Reset while a write is stalled in WR.
    @(posedge clk); #1;
    ram_rdy = 1'b0;
    start   = 1'b1;
    romsiz  = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = ram_we;
    end
    chk("rst_test_we_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ram_we", 32'(ram_we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rom_adr", 32'(rom_adr), 32'd0);
    rst     = 1'b0;
    ram_rdy = 1'b1;
    seen    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || ram_we) seen = 1'b1;
    end
    chk("midrst_quiet", 32'(seen), 32'd0);
    sb.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
